// File: rtl/joy_db15_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : joy_db15_responder_pkg
// Description : Shared constants for the DB15 joystick serial-chain responder.
//               Pad bit layout (bit0 = Right) and the active-low pin level
//               convention used on JOY_DATA.
// Revision    : 1.0 - initial release
// ============================================================================
package joy_db15_responder_pkg;

  // Bits per player pad word
  localparam int JOY_W = 12;

  // Pad word bit positions, active-high pressed
  localparam int JB_R      = 0;
  localparam int JB_L      = 1;
  localparam int JB_D      = 2;
  localparam int JB_U      = 3;
  localparam int JB_A      = 4;
  localparam int JB_B      = 5;
  localparam int JB_C      = 6;
  localparam int JB_BTN_D  = 7;
  localparam int JB_E      = 8;
  localparam int JB_F      = 9;
  localparam int JB_START  = 10;
  localparam int JB_SELECT = 11;

  // Serial line levels: a pressed button is driven low
  localparam logic JOY_PRESSED_LVL  = 1'b0;
  localparam logic JOY_RELEASED_LVL = 1'b1;

  // Converts an active-high "pressed" bit to the serial pin level.
  function automatic logic pin_level(input logic pressed);
    return pressed ? JOY_PRESSED_LVL : JOY_RELEASED_LVL;
  endfunction

endpackage : joy_db15_responder_pkg
`default_nettype wire

// File: rtl/joy_db15_responder_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : joy_db15_responder_sync_edge
// Description : Two-flop synchroniser for an asynchronous host pin plus a
//               history flop for edge detection. All flops reset to 1, the
//               idle level of the host lines, so releasing reset never
//               produces a spurious edge.
// Ports       : clk      - system clock
//               reset_n  - asynchronous active-low reset
//               din      - asynchronous input pin
//               sync     - synchronised level
//               rise     - one-cycle pulse on synchronised rising edge
//               fall     - one-cycle pulse on synchronised falling edge
// Revision    : 1.0 - initial release
// ============================================================================
module joy_db15_responder_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign sync = r_sync;
  assign rise =  r_sync & ~r_prev;
  assign fall = ~r_sync &  r_prev;

endmodule : joy_db15_responder_sync_edge
`default_nettype wire

// File: rtl/joy_db15_responder.sv
`default_nettype none
// ============================================================================
// Module      : joy_db15_responder
// Description : Far-end model of a DB15 joystick adapter: a 74HC165-style
//               parallel-in/serial-out chain. While JOY_LOAD is low both pad
//               words are captured; each JOY_CLK rising edge then shifts one
//               bit out on JOY_DATA (active low), player 1 bit 0 first.
//               Also reports host polling activity on link_active.
// Ports       : clk         - system clock
//               reset_n     - asynchronous active-low reset
//               joystick1   - player 1 pad, active-high pressed
//               joystick2   - player 2 pad, active-high pressed
//               JOY_CLK     - host shift clock (async), rising edge shifts
//               JOY_LOAD    - host parallel load (async), active low level
//               JOY_DATA    - serial data to host, 0 = pressed
//               bit_cnt     - bits shifted since last load, saturates at N
//               frame_done  - one-cycle pulse when bit_cnt reaches N
//               link_active - host loaded within the last TIMEOUT cycles
// Revision    : 1.0 - initial release
// ============================================================================
module joy_db15_responder
  import joy_db15_responder_pkg::*;
#(
  parameter int W       = JOY_W,
  parameter int PLAYERS = 2,
  parameter int TIMEOUT = 480000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [W-1:0]                    joystick1,
  input  logic [W-1:0]                    joystick2,
  input  logic                            JOY_CLK,
  input  logic                            JOY_LOAD,
  output logic                            JOY_DATA,
  output logic [$clog2(W*PLAYERS+1)-1:0]  bit_cnt,
  output logic                            frame_done,
  output logic                            link_active
);

  localparam int N  = W * PLAYERS;
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  // --------------------------------------------------------------------------
  // Host pin synchronisers
  // --------------------------------------------------------------------------
  logic w_clk_s, w_clk_rise, w_clk_fall;
  logic w_load_s, w_load_rise, w_load_fall;

  joy_db15_responder_sync_edge u_sync_clk (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (JOY_CLK),
    .sync    (w_clk_s),
    .rise    (w_clk_rise),
    .fall    (w_clk_fall)
  );

  joy_db15_responder_sync_edge u_sync_load (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (JOY_LOAD),
    .sync    (w_load_s),
    .rise    (w_load_rise),
    .fall    (w_load_fall)
  );

  // Edge/level outputs of the synchronisers that this block has no use for
  logic unused_sync;
  assign unused_sync = &{1'b0, w_clk_s, w_clk_fall, w_load_rise};

  // --------------------------------------------------------------------------
  // Pad capture and shift chain
  // --------------------------------------------------------------------------
  logic [W-1:0]  r_joy1_q;
  logic [W-1:0]  r_joy2_q;
  logic [N-1:0]  r_shreg;
  logic [N-1:0]  w_snapshot;
  logic [N-1:0]  w_shreg_d;
  logic [CW-1:0] w_cnt_d;
  logic          w_done_d;

  assign w_snapshot = {r_joy2_q, r_joy1_q};

  // Load level dominates: a clock edge coinciding with load is dropped.
  // Shift-in of 0 means "released", so over-clocking reads idle-high.
  always_comb begin
    w_shreg_d = r_shreg;
    w_cnt_d   = bit_cnt;
    w_done_d  = 1'b0;
    if (!w_load_s) begin
      w_shreg_d = w_snapshot;
      w_cnt_d   = '0;
    end else if (w_clk_rise) begin
      w_shreg_d = {1'b0, r_shreg[N-1:1]};
      if (bit_cnt != CW'(N)) begin
        w_cnt_d = bit_cnt + 1'b1;
      end
      w_done_d = (bit_cnt == CW'(N - 1));
    end
  end

  // JOY_DATA is taken from the next-state chain so the host sees the new bit
  // three clk cycles after its pin edge (two sync stages + this register).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_joy1_q   <= '0;
      r_joy2_q   <= '0;
      r_shreg    <= '0;
      bit_cnt    <= CW'(N);
      JOY_DATA   <= JOY_RELEASED_LVL;
      frame_done <= 1'b0;
    end else begin
      r_joy1_q   <= joystick1;
      r_joy2_q   <= joystick2;
      r_shreg    <= w_shreg_d;
      bit_cnt    <= w_cnt_d;
      JOY_DATA   <= pin_level(w_shreg_d[0]);
      frame_done <= w_done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Link activity timeout
  // --------------------------------------------------------------------------
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt    <= '0;
      link_active <= 1'b0;
    end else if (w_load_fall) begin
      r_to_cnt    <= '0;
      link_active <= 1'b1;
    end else if (r_to_cnt != TW'(TIMEOUT)) begin
      r_to_cnt    <= r_to_cnt + 1'b1;
    end else begin
      link_active <= 1'b0;
    end
  end

endmodule : joy_db15_responder
`default_nettype wire

// File: tb/tb_joy_db15_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_joy_db15_responder
// Description : Self-checking bench for joy_db15_responder. Expected serial
//               bits are queued when a pad snapshot is loaded and popped as
//               each bit is presented on JOY_DATA.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_joy_db15_responder;

  localparam int W   = 12;
  localparam int N   = 24;
  localparam int CW  = 5;
  localparam int TO  = 200;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  joystick1 = '0;
  logic [W-1:0]  joystick2 = '0;
  logic          JOY_CLK = 1'b0;
  logic          JOY_LOAD = 1'b1;
  logic          JOY_DATA;
  logic [CW-1:0] bit_cnt;
  logic          frame_done;
  logic          link_active;

  int checks = 0;
  int errors = 0;
  int fd_total = 0;
  logic exp_q[$];

  joy_db15_responder #(.W(W), .PLAYERS(2), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .joystick1   (joystick1),
    .joystick2   (joystick2),
    .JOY_CLK     (JOY_CLK),
    .JOY_LOAD    (JOY_LOAD),
    .JOY_DATA    (JOY_DATA),
    .bit_cnt     (bit_cnt),
    .frame_done  (frame_done),
    .link_active (link_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done === 1'b1) fd_total <= fd_total + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive pads, pulse LOAD and queue the expected active-low bit stream.
  task automatic load_pads(input logic [W-1:0] j1, input logic [W-1:0] j2);
    joystick1 = j1;
    joystick2 = j2;
    JOY_LOAD  = 1'b0;
    wait_clk(4);
    JOY_LOAD  = 1'b1;
    wait_clk(4);
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      if (i < W) exp_q.push_back(~j1[i]);
      else       exp_q.push_back(~j2[i-W]);
    end
  endtask

  task automatic pulse_clk();
    JOY_CLK = 1'b1;
    wait_clk(4);
    JOY_CLK = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_clk(3);
    checks++; if (JOY_DATA !== 1'b1) begin errors++; $display("FAIL reset_data: got %b want 1", JOY_DATA); end
    checks++; if (bit_cnt !== 5'd24) begin errors++; $display("FAIL reset_cnt: got %0d want 24", bit_cnt); end
    checks++; if (link_active !== 1'b0) begin errors++; $display("FAIL reset_link: got %b want 0", link_active); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
    reset_n = 1'b1;
    wait_clk(10);
    checks++; if (JOY_DATA !== 1'b1) begin errors++; $display("FAIL idle_data: got %b want 1", JOY_DATA); end
    checks++; if (bit_cnt !== 5'd24) begin errors++; $display("FAIL idle_cnt: got %0d want 24", bit_cnt); end
    checks++; if (link_active !== 1'b0) begin errors++; $display("FAIL idle_link: got %b want 0", link_active); end
  endtask

  task automatic test_frame();
    int fd0;
    logic exp;
    load_pads(12'h001, 12'h800);
    fd0 = fd_total;
    checks++; if (bit_cnt !== 5'd0) begin errors++; $display("FAIL frame_cnt0: got %0d want 0", bit_cnt); end
    for (int p = 0; p < N; p++) begin
      exp = exp_q.pop_front();
      checks++; if (JOY_DATA !== exp) begin errors++; $display("FAIL frame_bit %0d: got %b want %b", p, JOY_DATA, exp); end
      if (p == N - 1) begin
        checks++; if (fd_total - fd0 !== 0) begin errors++; $display("FAIL frame_early_done: got %0d want 0", fd_total - fd0); end
      end
      pulse_clk();
    end
    checks++; if (fd_total - fd0 !== 1) begin errors++; $display("FAIL frame_done_cnt: got %0d want 1", fd_total - fd0); end
    checks++; if (bit_cnt !== 5'd24) begin errors++; $display("FAIL frame_cnt_end: got %0d want 24", bit_cnt); end
  endtask

  task automatic test_overclock();
    int fd0;
    logic exp;
    load_pads(12'hA5C, 12'h3F1);
    fd0 = fd_total;
    for (int p = 0; p < 30; p++) begin
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b1;
      checks++; if (JOY_DATA !== exp) begin errors++; $display("FAIL over_bit %0d: got %b want %b", p, JOY_DATA, exp); end
      pulse_clk();
    end
    checks++; if (JOY_DATA !== 1'b1) begin errors++; $display("FAIL over_fill: got %b want 1", JOY_DATA); end
    checks++; if (bit_cnt !== 5'd24) begin errors++; $display("FAIL over_cnt: got %0d want 24", bit_cnt); end
    checks++; if (fd_total - fd0 !== 1) begin errors++; $display("FAIL over_done_cnt: got %0d want 1", fd_total - fd0); end
  endtask

  task automatic test_abort();
    int fd0;
    logic exp;
    load_pads(12'h5A3, 12'hC3C);
    fd0 = fd_total;
    for (int p = 0; p < 10; p++) begin
      exp = exp_q.pop_front();
      checks++; if (JOY_DATA !== exp) begin errors++; $display("FAIL abort_bit %0d: got %b want %b", p, JOY_DATA, exp); end
      pulse_clk();
    end
    load_pads(12'h0F1, 12'h90E);
    checks++; if (bit_cnt !== 5'd0) begin errors++; $display("FAIL abort_cnt: got %0d want 0", bit_cnt); end
    checks++; if (JOY_DATA !== 1'b0) begin errors++; $display("FAIL abort_data: got %b want 0", JOY_DATA); end
    checks++; if (fd_total - fd0 !== 0) begin errors++; $display("FAIL abort_done: got %0d want 0", fd_total - fd0); end
    for (int p = 0; p < N; p++) begin
      exp = exp_q.pop_front();
      checks++; if (JOY_DATA !== exp) begin errors++; $display("FAIL restart_bit %0d: got %b want %b", p, JOY_DATA, exp); end
      pulse_clk();
    end
    checks++; if (fd_total - fd0 !== 1) begin errors++; $display("FAIL restart_done: got %0d want 1", fd_total - fd0); end
  endtask

  task automatic test_pad_change();
    logic exp;
    load_pads(12'h001, 12'h000);
    joystick1 = 12'h002;
    for (int p = 0; p < N; p++) begin
      exp = exp_q.pop_front();
      checks++; if (JOY_DATA !== exp) begin errors++; $display("FAIL padchg_bit %0d: got %b want %b", p, JOY_DATA, exp); end
      pulse_clk();
    end
  endtask

  task automatic test_link();
    wait_clk(TO + 20);
    checks++; if (link_active !== 1'b0) begin errors++; $display("FAIL link_idle: got %b want 0", link_active); end
    // Slow polling: link drops between polls
    for (int k = 0; k < 2; k++) begin
      JOY_LOAD = 1'b0;
      wait_clk(4);
      JOY_LOAD = 1'b1;
      wait_clk(TO - 9);
      checks++; if (link_active !== 1'b1) begin errors++; $display("FAIL link_before_to %0d: got %b want 1", k, link_active); end
      wait_clk(15);
      checks++; if (link_active !== 1'b0) begin errors++; $display("FAIL link_after_to %0d: got %b want 0", k, link_active); end
    end
    // Fast polling: link stays up
    for (int k = 0; k < 20; k++) begin
      JOY_LOAD = 1'b0;
      wait_clk(4);
      JOY_LOAD = 1'b1;
      wait_clk(16);
      checks++; if (link_active !== 1'b1) begin errors++; $display("FAIL link_fast %0d: got %b want 1", k, link_active); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int fd0;
    load_pads(12'h0FF, 12'hF00);
    fd0 = fd_total;
    repeat (5) pulse_clk();
    checks++; if (JOY_DATA !== 1'b0) begin errors++; $display("FAIL mid_data: got %b want 0", JOY_DATA); end
    checks++; if (link_active !== 1'b1) begin errors++; $display("FAIL mid_link: got %b want 1", link_active); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (JOY_DATA !== 1'b1) begin errors++; $display("FAIL rst_mid_data: got %b want 1", JOY_DATA); end
    checks++; if (bit_cnt !== 5'd24) begin errors++; $display("FAIL rst_mid_cnt: got %0d want 24", bit_cnt); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", frame_done); end
    checks++; if (link_active !== 1'b0) begin errors++; $display("FAIL rst_mid_link: got %b want 0", link_active); end
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(4);
    repeat (3) pulse_clk();
    checks++; if (JOY_DATA !== 1'b1) begin errors++; $display("FAIL post_rst_data: got %b want 1", JOY_DATA); end
    checks++; if (bit_cnt !== 5'd24) begin errors++; $display("FAIL post_rst_cnt: got %0d want 24", bit_cnt); end
    checks++; if (fd_total - fd0 !== 0) begin errors++; $display("FAIL post_rst_done: got %0d want 0", fd_total - fd0); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_overclock();
    test_abort();
    test_pad_change();
    test_link();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_joy_db15_responder
`default_nettype wire
